multi_timer: RTL and testbench
==============================

MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent timer channels; SHALL be 1..16.
REQ-002 Parameter CNT_W, default 16: width of each channel's period and count.
REQ-003 Parameter CLKS_PER_MS, default 50000: clk cycles per shared ms tick; SHALL be at least 2.
REQ-004 Parameter DEFAULT_PERIOD, default 1000: period loaded into every channel at reset.
REQ-005 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 tick_en  in  1  enables the shared prescaler.
REQ-008 cfg_we  in  1  writes the configuration of channel ch_sel.
REQ-009 ch_sel  in  max(1,$clog2(NUM_CH))  channel selected by cfg_we.
REQ-010 cfg_period  in  CNT_W  period in ticks.
REQ-011 cfg_up  in  1  1 = count up, 0 = count down.
REQ-012 cfg_periodic  in  1  1 = auto-reload, 0 = one-shot.
REQ-013 start  in  NUM_CH  per-channel start/restart request, one bit per channel.
REQ-014 stop  in  NUM_CH  per-channel stop request.
REQ-015 irq_ack  in  NUM_CH  per-channel clear of irq_pending.
REQ-016 count  out  NUM_CH*CNT_W  current counts, channel i in bits [i*CNT_W +: CNT_W].
REQ-017 running  out  NUM_CH  channel is in RUN state.
REQ-018 expire  out  NUM_CH  one-cycle expiry pulse per channel.
REQ-019 irq_pending  out  NUM_CH  sticky expiry flags.
REQ-020 irq  out  1  OR of irq_pending.

Function
REQ-021 The prescaler SHALL count 0..CLKS_PER_MS-1 while tick_en=1, raise internal tick for one cycle at CLKS_PER_MS-1, and wrap to 0.
- While tick_en=0 it SHALL hold its value and generate no tick.
REQ-022 Effective period P SHALL be max(cfg_period,1); period 0 behaves as 1, so the channel expires on every tick.
REQ-023 cfg_we SHALL latch period, up and periodic for channel ch_sel.
- ch_sel>=NUM_CH SHALL be ignored.
- A write to a running channel SHALL NOT alter its count; the new values apply from the next tick compare, reload or start.
REQ-024 Each channel SHALL be an FSM with states IDLE and RUN.
- IDLE->RUN on start.
- RUN->IDLE on stop or on one-shot expiry.
- running=1 exactly in RUN.
REQ-025 On start the count SHALL load 0 (up) or P-1 (down).
- start while in RUN SHALL restart the channel the same way.
- A coincident tick SHALL be ignored for that channel.
REQ-026 Up mode, tick in RUN with count>=P-1: expire; periodic loads 0; one-shot holds P-1 and goes to IDLE.
- Any other tick increments the count by 1.
REQ-027 Down mode, tick in RUN with count==0: expire; periodic loads P-1; one-shot holds 0 and goes to IDLE.
- Any other tick decrements the count by 1.
REQ-028 expire[i] SHALL be registered and high for exactly the one cycle in which count shows the post-expiry value.
REQ-029 start and stop asserted together on a channel: stop SHALL win; the channel ends IDLE with its count unchanged.
REQ-030 stop SHALL freeze the count at its current value; ticks in IDLE SHALL have no effect.
REQ-031 irq_pending[i] SHALL set on expire[i] and clear on irq_ack[i]; set SHALL win when both occur in the same cycle.
REQ-032 irq SHALL be combinational OR of irq_pending.

Reset
REQ-033 On reset, for all channels:
- prescaler=0;
- count=0, running=0, expire=0, irq_pending=0, irq=0;
- period=DEFAULT_PERIOD, up=1, periodic=1.
REQ-034 Reset SHALL take priority over all inputs and abort any channel in RUN.

Verification (NUM_CH=2, CNT_W=8, CLKS_PER_MS=4)
REQ-035 Up periodic: tick_en=1, ch0 period=3, up=1, periodic=1, start[0] -> count0 0,1,2,0,... changing every 4 clk; expire[0] pulses every 12 clk; irq and irq_pending[0]=1.
REQ-036 Down one-shot: ch1 period=2, up=0, periodic=0, start[1] -> count1 1, then 0; the next tick pulses expire[1]; running[1]=0; count1 holds 0.
REQ-037 Controls: start[0] and stop[0] in the same cycle -> running[0] stays 0.
- stop mid-run -> count frozen.
- Later start -> count reloads 0.
REQ-038 irq_ack[0] coincident with expire[0] -> irq_pending[0] stays 1; irq_ack[0] alone next cycle -> irq_pending[0]=0, irq=0.
REQ-039 period=0 -> expire every tick (4 clk). tick_en=0 -> counts frozen. reset mid-run -> all outputs 0 on the following cycle.

Source files
------------

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH independent tick timers sharing one ms prescaler.
// Each channel counts up or down, one-shot or auto-reload, and raises a
// sticky interrupt flag on expiry.
//
// Handshake/control semantics: start/stop/irq_ack/cfg_we are single-cycle
// level requests sampled on the rising clk edge; there is no back-pressure.
// Per channel, priority is reset > stop > start > tick.
module multi_timer #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 16,
  parameter int CLKS_PER_MS    = 50000,
  parameter int DEFAULT_PERIOD = 1000,
  localparam int SEL_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick_en,
  input  logic                    cfg_we,
  input  logic [SEL_W-1:0]        ch_sel,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic                    cfg_up,
  input  logic                    cfg_periodic,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       irq_ack,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic [NUM_CH-1:0]       running,
  output logic [NUM_CH-1:0]       expire,
  output logic [NUM_CH-1:0]       irq_pending,
  output logic                    irq
);

  localparam int PS_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  logic [PS_W-1:0] presc_q;
  logic            tick;

  // Tick is asserted during the last prescaler cycle; channels act on that edge.
  assign tick = tick_en && (presc_q == PS_W'(CLKS_PER_MS - 1));

  // Shared prescaler: counts while enabled, wraps on tick, holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else if (tick_en) begin
      if (tick) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + PS_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_e           state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] eff_p;
    logic [CNT_W-1:0] eff_p_m1;
    logic             up_q;
    logic             periodic_q;
    logic             expire_q;
    logic             pend_q;
    logic             pend_d;
    logic             cfg_hit;

    // A period of zero behaves as one so the channel expires on every tick.
    assign eff_p    = (period_q == '0) ? CNT_W'(1) : period_q;
    assign eff_p_m1 = eff_p - CNT_W'(1);
    // Out-of-range ch_sel values never match any channel index.
    assign cfg_hit  = cfg_we && (ch_sel == SEL_W'(i));

    // Configuration registers; a write never touches the running count.
    always_ff @(posedge clk) begin
      if (reset) begin
        period_q   <= CNT_W'(DEFAULT_PERIOD);
        up_q       <= 1'b1;
        periodic_q <= 1'b1;
      end else if (cfg_hit) begin
        period_q   <= cfg_period;
        up_q       <= cfg_up;
        periodic_q <= cfg_periodic;
      end
    end

    // Channel FSM with count and registered expiry pulse.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q  <= ST_IDLE;
        count_q  <= '0;
        expire_q <= 1'b0;
      end else begin
        expire_q <= 1'b0;
        if (stop[i]) begin
          // Stop wins over a coincident start and freezes the count.
          state_q <= ST_IDLE;
        end else if (start[i]) begin
          // Start or restart; any coincident tick is discarded.
          state_q <= ST_RUN;
          count_q <= up_q ? '0 : eff_p_m1;
        end else if ((state_q == ST_RUN) && tick) begin
          if (up_q) begin
            if (count_q >= eff_p_m1) begin
              expire_q <= 1'b1;
              if (periodic_q) begin
                count_q <= '0;
              end else begin
                count_q <= eff_p_m1;
                state_q <= ST_IDLE;
              end
            end else begin
              count_q <= count_q + CNT_W'(1);
            end
          end else begin
            if (count_q == '0) begin
              expire_q <= 1'b1;
              if (periodic_q) begin
                count_q <= eff_p_m1;
              end else begin
                count_q <= '0;
                state_q <= ST_IDLE;
              end
            end else begin
              count_q <= count_q - CNT_W'(1);
            end
          end
        end
      end
    end

    // Sticky flag: a visible expiry pulse sets it and beats a coincident ack.
    always_comb begin
      pend_d = pend_q;
      if (expire_q) begin
        pend_d = 1'b1;
      end else if (irq_ack[i]) begin
        pend_d = 1'b0;
      end
    end

    // Interrupt pending register.
    always_ff @(posedge clk) begin
      if (reset) begin
        pend_q <= 1'b0;
      end else begin
        pend_q <= pend_d;
      end
    end

    assign count[i*CNT_W +: CNT_W] = count_q;
    assign running[i]              = (state_q == ST_RUN);
    assign expire[i]               = expire_q;
    assign irq_pending[i]          = pend_q;
  end

  assign irq = |irq_pending;

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer with NUM_CH=2, CNT_W=8, CLKS_PER_MS=4.
module tb_multi_timer;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam int CPM    = 4;

  // ---------------- clock / reset / DUT ----------------
  logic                    clk = 1'b0;
  logic                    reset;
  logic                    tick_en;
  logic                    cfg_we;
  logic                    ch_sel;
  logic [CNT_W-1:0]        cfg_period;
  logic                    cfg_up;
  logic                    cfg_periodic;
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       stop;
  logic [NUM_CH-1:0]       irq_ack;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [NUM_CH-1:0]       running;
  logic [NUM_CH-1:0]       expire;
  logic [NUM_CH-1:0]       irq_pending;
  logic                    irq;

  always #5 clk = ~clk;

  multi_timer #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CLKS_PER_MS(CPM), .DEFAULT_PERIOD(1000)
  ) dut (
    .clk(clk), .reset(reset), .tick_en(tick_en), .cfg_we(cfg_we),
    .ch_sel(ch_sel), .cfg_period(cfg_period), .cfg_up(cfg_up),
    .cfg_periodic(cfg_periodic), .start(start), .stop(stop),
    .irq_ack(irq_ack), .count(count), .running(running), .expire(expire),
    .irq_pending(irq_pending), .irq(irq)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  int m_presc;
  int m_cnt   [NUM_CH];
  int m_per   [NUM_CH];
  bit m_run   [NUM_CH];
  bit m_up    [NUM_CH];
  bit m_pmode [NUM_CH];
  bit m_exp   [NUM_CH];
  bit m_pend  [NUM_CH];

  task automatic model_reset();
    m_presc = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i] = 0; m_run[i] = 0; m_exp[i] = 0; m_pend[i] = 0;
      m_per[i] = 1000 % 256; m_up[i] = 1; m_pmode[i] = 1;
    end
  endtask

  // One clock edge of the timer rules, using the inputs present at the edge.
  task automatic model_step();
    bit tk;
    int p;
    if (reset) begin
      model_reset();
      return;
    end
    tk = tick_en && (m_presc == CPM - 1);
    for (int i = 0; i < NUM_CH; i++) begin
      m_pend[i] = m_exp[i] ? 1'b1 : (irq_ack[i] ? 1'b0 : m_pend[i]);
      m_exp[i]  = 0;
      p = (m_per[i] == 0) ? 1 : m_per[i];
      if (stop[i]) begin
        m_run[i] = 0;
      end else if (start[i]) begin
        m_run[i] = 1;
        m_cnt[i] = m_up[i] ? 0 : p - 1;
      end else if (m_run[i] && tk) begin
        if (m_up[i] ? (m_cnt[i] >= p - 1) : (m_cnt[i] == 0)) begin
          m_exp[i] = 1;
          if (m_pmode[i]) m_cnt[i] = m_up[i] ? 0 : p - 1;
          else begin
            m_cnt[i] = m_up[i] ? p - 1 : 0;
            m_run[i] = 0;
          end
        end else begin
          m_cnt[i] = m_up[i] ? m_cnt[i] + 1 : m_cnt[i] - 1;
        end
      end
    end
    if (cfg_we && (int'(ch_sel) < NUM_CH)) begin
      m_per[ch_sel]   = int'(cfg_period);
      m_up[ch_sel]    = cfg_up;
      m_pmode[ch_sel] = cfg_periodic;
    end
    if (tick_en) m_presc = (m_presc + 1) % CPM;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit any_pend;
    any_pend = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      chk($sformatf("m_count%0d", i), 32'(count[i*CNT_W +: CNT_W]), 32'(m_cnt[i]));
      chk($sformatf("m_running%0d", i), 32'(running[i]), 32'(m_run[i]));
      chk($sformatf("m_expire%0d", i), 32'(expire[i]), 32'(m_exp[i]));
      chk($sformatf("m_pend%0d", i), 32'(irq_pending[i]), 32'(m_pend[i]));
      any_pend |= m_pend[i];
    end
    chk("m_irq", 32'(irq), 32'(any_pend));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    reset = 0; cfg_we = 0; ch_sel = 0; cfg_period = 0; cfg_up = 0;
    cfg_periodic = 0; start = 0; stop = 0; irq_ack = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
  endtask

  task automatic cfg(input logic sel, input logic [7:0] per, input logic up, input logic pm);
    cfg_we = 1; ch_sel = sel; cfg_period = per; cfg_up = up; cfg_periodic = pm;
    step();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       we;
    logic       sel;
    logic [7:0] per;
    logic       up;
    logic       pm;
    logic [1:0] st;
    logic [1:0] sp;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [1:0] erun;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 8'd5, 1'b0, 1'b0, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00};
    tbl[1]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'b10, 2'b00, 8'd0, 8'd4, 2'b10};
    tbl[2]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'b01, 2'b00, 8'd0, 8'd4, 2'b11};
    tbl[3]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'b00, 2'b10, 8'd0, 8'd4, 2'b01};
    tbl[4]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'b10, 2'b10, 8'd0, 8'd4, 2'b01};
    tbl[5]  = '{1'b1, 1'b0, 8'd7, 1'b0, 1'b1, 2'b00, 2'b00, 8'd0, 8'd4, 2'b01};
    tbl[6]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'b01, 2'b00, 8'd6, 8'd4, 2'b01};
    tbl[7]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'b00, 2'b01, 8'd6, 8'd4, 2'b00};
    tbl[8]  = '{1'b1, 1'b1, 8'd0, 1'b0, 1'b1, 2'b00, 2'b00, 8'd6, 8'd4, 2'b00};
    tbl[9]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'b10, 2'b00, 8'd6, 8'd0, 2'b10};
    tbl[10] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'b00, 2'b10, 8'd6, 8'd0, 2'b00};

    idle_inputs();
    tick_en = 0;
    model_reset();

    // Reset state.
    do_reset();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_expire", 32'(expire), 32'd0);
    chk("rst_pend", 32'(irq_pending), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);

    // Table: control/config behaviour with the prescaler held.
    for (int r = 0; r < 11; r++) begin
      cfg_we = tbl[r].we; ch_sel = tbl[r].sel; cfg_period = tbl[r].per;
      cfg_up = tbl[r].up; cfg_periodic = tbl[r].pm;
      start = tbl[r].st; stop = tbl[r].sp;
      step();
      chk($sformatf("tbl%0d_count0", r), 32'(count[7:0]), 32'(tbl[r].e0));
      chk($sformatf("tbl%0d_count1", r), 32'(count[15:8]), 32'(tbl[r].e1));
      chk($sformatf("tbl%0d_running", r), 32'(running), 32'(tbl[r].erun));
    end

    // Up periodic, irq ack ordering, stop freeze and restart.
    do_reset();
    tick_en = 0;
    cfg(1'b0, 8'd3, 1'b1, 1'b1);
    start = 2'b01;
    step();
    chk("a_start_count0", 32'(count[7:0]), 32'd0);
    chk("a_start_run0", 32'(running[0]), 32'd1);
    for (int s = 1; s <= 37; s++) begin
      tick_en = 1;
      if (s == 20 || s == 25 || s == 26) irq_ack = 2'b01;
      if (s == 31) stop = 2'b01;
      if (s == 37) start = 2'b01;
      step();
      if (s == 4)  chk("a_cnt_s4", 32'(count[7:0]), 32'd1);
      if (s == 8)  chk("a_cnt_s8", 32'(count[7:0]), 32'd2);
      if (s == 11) chk("a_exp_s11", 32'(expire[0]), 32'd0);
      if (s == 12) begin
        chk("a_cnt_s12", 32'(count[7:0]), 32'd0);
        chk("a_exp_s12", 32'(expire[0]), 32'd1);
      end
      if (s == 13) begin
        chk("a_exp_s13", 32'(expire[0]), 32'd0);
        chk("a_pend_s13", 32'(irq_pending[0]), 32'd1);
        chk("a_irq_s13", 32'(irq), 32'd1);
      end
      if (s == 20) chk("a_ack_s20", 32'(irq_pending[0]), 32'd0);
      if (s == 24) chk("a_exp_s24", 32'(expire[0]), 32'd1);
      if (s == 25) chk("a_setwins_s25", 32'(irq_pending[0]), 32'd1);
      if (s == 26) begin
        chk("a_ack_s26", 32'(irq_pending[0]), 32'd0);
        chk("a_irq_s26", 32'(irq), 32'd0);
      end
      if (s == 28) chk("a_cnt_s28", 32'(count[7:0]), 32'd1);
      if (s == 31) begin
        chk("a_stop_run", 32'(running[0]), 32'd0);
        chk("a_stop_cnt", 32'(count[7:0]), 32'd1);
      end
      if (s == 36) chk("a_frozen_cnt", 32'(count[7:0]), 32'd1);
      if (s == 37) begin
        chk("a_restart_cnt", 32'(count[7:0]), 32'd0);
        chk("a_restart_run", 32'(running[0]), 32'd1);
      end
    end

    // Down one-shot.
    do_reset();
    tick_en = 0;
    cfg(1'b1, 8'd2, 1'b0, 1'b0);
    start = 2'b10;
    step();
    chk("b_start_cnt1", 32'(count[15:8]), 32'd1);
    chk("b_start_run1", 32'(running[1]), 32'd1);
    for (int s = 1; s <= 12; s++) begin
      tick_en = 1;
      step();
      if (s == 4) begin
        chk("b_cnt_s4", 32'(count[15:8]), 32'd0);
        chk("b_exp_s4", 32'(expire[1]), 32'd0);
      end
      if (s == 8) begin
        chk("b_exp_s8", 32'(expire[1]), 32'd1);
        chk("b_run_s8", 32'(running[1]), 32'd0);
        chk("b_cnt_s8", 32'(count[15:8]), 32'd0);
      end
      if (s == 12) begin
        chk("b_cnt_s12", 32'(count[15:8]), 32'd0);
        chk("b_exp_s12", 32'(expire[1]), 32'd0);
      end
    end

    // Period zero, tick_en gating, reset mid-run.
    do_reset();
    tick_en = 0;
    cfg(1'b0, 8'd0, 1'b1, 1'b1);
    start = 2'b01;
    step();
    cfg(1'b1, 8'd5, 1'b0, 1'b1);
    start = 2'b10;
    step();
    chk("c_start_cnt1", 32'(count[15:8]), 32'd4);
    for (int s = 1; s <= 8; s++) begin
      tick_en = 1;
      step();
      if (s == 4) begin
        chk("c_exp0_s4", 32'(expire[0]), 32'd1);
        chk("c_cnt1_s4", 32'(count[15:8]), 32'd3);
      end
      if (s == 5) chk("c_exp0_s5", 32'(expire[0]), 32'd0);
      if (s == 8) begin
        chk("c_exp0_s8", 32'(expire[0]), 32'd1);
        chk("c_cnt1_s8", 32'(count[15:8]), 32'd2);
      end
    end
    for (int s = 1; s <= 10; s++) begin
      tick_en = 0;
      step();
    end
    chk("c_frozen_cnt1", 32'(count[15:8]), 32'd2);
    chk("c_frozen_exp", 32'(expire), 32'd0);
    chk("c_pend_before_rst", 32'(irq_pending[0]), 32'd1);
    tick_en = 1;
    do_reset();
    chk("c_rst_count", 32'(count), 32'd0);
    chk("c_rst_running", 32'(running), 32'd0);
    chk("c_rst_expire", 32'(expire), 32'd0);
    chk("c_rst_pend", 32'(irq_pending), 32'd0);
    chk("c_rst_irq", 32'(irq), 32'd0);

    // Randomized stimulus against the model.
    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(0, 299) == 0);
      tick_en      = ($urandom_range(0, 9) != 0);
      cfg_we       = ($urandom_range(0, 7) == 0);
      ch_sel       = 1'($urandom_range(0, 1));
      cfg_period   = 8'($urandom_range(0, 4));
      cfg_up       = 1'($urandom_range(0, 1));
      cfg_periodic = 1'($urandom_range(0, 1));
      for (int i = 0; i < NUM_CH; i++) begin
        start[i]   = ($urandom_range(0, 15) == 0);
        stop[i]    = ($urandom_range(0, 23) == 0);
        irq_ack[i] = ($urandom_range(0, 3) == 0);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
